// File: rtl/key_expand_serial.sv
// rtl/key_expand_serial.sv - byte-serial AES-128 key schedule with one shared S-box

// AES S-box: multiplicative inverse in GF(2^8) (as x^254) followed by the affine map
module sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // inv = a^(2+4+...+128) = a^254, which maps 0 to 0 as the S-box requires
  always_comb begin
    sq  = a_i;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module key_expand_serial #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_in,
  input  logic       load_en,
  input  logic       next,
  output logic [7:0] key_out,
  output logic       key_valid,
  output logic [3:0] round_idx,
  output logic       ready,
  output logic       done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_READY  = 3'd2;
  localparam logic [2:0] S_EXPAND = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  logic [2:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  // Position p of the shift register is key_q[127-8p -: 8]; bytes move toward position 0
  logic [127:0] key_q, key_d;
  logic [7:0]   out_q, out_d;
  logic         valid_q, valid_d;
  logic         ready_q, ready_d;
  logic         done_q, done_d;

  logic [7:0] pos0, pos9, pos12, pos13;
  logic [7:0] sbox_in, sbox_out, new_byte;

  assign pos0  = key_q[127:120];
  assign pos9  = key_q[55:48];
  assign pos12 = key_q[31:24];
  assign pos13 = key_q[23:16];

  // During byte i the register holds old k[i..15] then new n[0..i-1]; the rotated
  // word byte k[12+((i+1)%4)] sits at position 13 for i<3 and position 9 for i==3,
  // and n[i-4] always sits at position 12
  assign sbox_in = (cnt_q == 4'd3) ? pos9 : pos13;

  sbox u_sbox (
    .a_i (sbox_in),
    .s_o (sbox_out)
  );

  // Next round-key byte from the current register contents
  always_comb begin
    new_byte = pos0 ^ pos12;
    if (cnt_q < 4'd4) begin
      new_byte = pos0 ^ sbox_out ^ ((cnt_q == 4'd0) ? rcon_q : 8'h00);
    end
  end

  // Sequencing of load, hold and expansion, one byte per cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    key_d   = key_q;
    out_d   = out_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE, S_READY, S_DONE: begin
        if (load_en) begin
          key_d   = {key_q[119:0], key_in};
          out_d   = key_in;
          valid_d = 1'b1;
          cnt_d   = 4'd1;
          round_d = 4'd0;
          rcon_d  = 8'h01;
          state_d = S_LOAD;
        end else if ((state_q == S_READY) && next) begin
          round_d = round_q + 4'd1;
          cnt_d   = 4'd0;
          state_d = S_EXPAND;
        end
      end
      S_LOAD: begin
        if (load_en) begin
          key_d   = {key_q[119:0], key_in};
          out_d   = key_in;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = S_READY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXPAND: begin
        key_d   = {key_q[119:0], new_byte};
        out_d   = new_byte;
        valid_d = 1'b1;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          state_d = (round_q == LAST_ROUND) ? S_DONE : S_READY;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_READY);
    done_d  = (state_d == S_DONE);
  end

  // State registers, cleared asynchronously so outputs drop the moment rst falls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      round_q <= 4'd0;
      rcon_q  <= 8'h01;
      key_q   <= 128'd0;
      out_q   <= 8'h00;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      key_q   <= key_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign key_out   = out_q;
  assign key_valid = valid_q;
  assign round_idx = round_q;
  assign ready     = ready_q;
  assign done      = done_q;

endmodule

// File: tb/tb_key_expand_serial.sv
// tb/tb_key_expand_serial.sv - randomized bench for key_expand_serial against a word-level key schedule model

module tb_key_expand_serial;

  localparam int NR = 10;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] key_in = 8'h00;
  logic       load_en = 1'b0;
  logic       next = 1'b0;
  logic [7:0] key_out;
  logic       key_valid;
  logic [3:0] round_idx;
  logic       ready;
  logic       done;

  key_expand_serial #(.NUM_ROUNDS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .load_en   (load_en),
    .next      (next),
    .key_out   (key_out),
    .key_valid (key_valid),
    .round_idx (round_idx),
    .ready     (ready),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         c;
    logic [7:0] b;
    logic [3:0] r;
  } exp_t;
  exp_t expq[$];

  logic [7:0] sbox_tab [0:255];
  logic [7:0] rcon_tab [1:10];

  logic [127:0] m_key;
  int           m_round;
  bit           m_ready;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Brute-force inverse search, then the affine transform
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 word-oriented schedule: w[i] = w[i-4] ^ f(w[i-1])
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {w3[23:0], w3[31:24]};
    t  = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
    t  = t ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Every output cycle is matched in order and in time against the expected-byte queue
  always @(negedge clk) begin
    if (rst) begin
      if (key_valid) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid cyc=%0d got=%h round=%0d want=no output", cyc, key_out, round_idx);
        end else begin
          exp_t e;
          e = expq.pop_front();
          if (e.c != cyc || e.b !== key_out || e.r !== round_idx) begin
            errors++;
            $display("FAIL key_byte cyc=%0d got=%h/r%0d want=%h/r%0d at cyc %0d",
                     cyc, key_out, round_idx, e.b, e.r, e.c);
          end
        end
      end else if (expq.size() > 0 && expq[0].c <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_byte cyc=%0d got=no valid want=%h/r%0d", cyc, expq[0].b, expq[0].r);
        void'(expq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_key(input logic [127:0] k, input int r, input int start, input int nb);
    for (int i = 0; i < nb; i++) begin
      exp_t e;
      e.c = start + i;
      e.b = k[127 - 8*i -: 8];
      e.r = 4'(r);
      expq.push_back(e);
    end
  endtask

  task automatic load_key(input logic [127:0] k, input int nb);
    for (int i = 0; i < nb; i++) begin
      load_en = 1'b1;
      key_in  = k[127 - 8*i -: 8];
      push_key(k << (8*i), 0, cyc + 1, 1);
      tick();
    end
    load_en = 1'b0;
    key_in  = 8'h00;
    m_key   = k;
    m_round = 0;
    m_ready = (nb == 16);
    chk("ready_after_load", 128'(ready), 128'(nb == 16));
    chk("done_after_load", 128'(done), 128'd0);
  endtask

  task automatic pulse_next(input int nb);
    int t;
    next = 1'b1;
    t = cyc + 1;
    if (m_ready) begin
      m_round++;
      m_key = next_key(m_key, rcon_tab[m_round]);
      push_key(m_key, m_round, t + 1, nb);
      if (m_round == NR) m_ready = 0;
    end
    tick();
    next = 1'b0;
  endtask

  initial begin
    logic [127:0] k;
    int t0;
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    build_sbox();
    m_key = 128'd0; m_round = 0; m_ready = 0;

    chk("model_sbox_00", 128'(sbox_tab[8'h00]), 128'h63);
    chk("model_sbox_01", 128'(sbox_tab[8'h01]), 128'h7c);
    chk("model_sbox_53", 128'(sbox_tab[8'h53]), 128'hed);
    k = next_key(FIPS_KEY, 8'h01);
    chk("model_rk1", k, 128'ha0fafe1788542cb123a339392a6c7605);
    k = next_key(k, 8'h02);
    chk("model_rk2", k, 128'hf2c295f27a96b9435935807a7359f67f);
    for (int r = 3; r <= NR; r++) k = next_key(k, rcon_tab[r]);
    chk("model_rk10", k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    idle(3);
    chk("reset_key_out", 128'(key_out), 128'd0);
    chk("reset_key_valid", 128'(key_valid), 128'd0);
    chk("reset_round_idx", 128'(round_idx), 128'd0);
    chk("reset_ready", 128'(ready), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    rst = 1'b1;
    idle(2);

    // Known-answer key, two single-step rounds
    load_key(FIPS_KEY, 16);
    idle($urandom_range(0, 3));
    pulse_next(16); idle(16 + $urandom_range(0, 3));
    pulse_next(16); idle(16);

    // Restart from READY, then next held high through all rounds
    load_key(FIPS_KEY, 16);
    next = 1'b1;
    t0 = cyc + 1;
    for (int r = 1; r <= NR; r++) begin
      m_key = next_key(m_key, rcon_tab[r]);
      push_key(m_key, r, t0 + 17*(r-1) + 1, 16);
    end
    m_round = NR; m_ready = 0;
    idle(17*NR + 10);
    chk("done_after_hold", 128'(done), 128'd1);
    chk("ready_in_done", 128'(ready), 128'd0);
    idle(20);
    next = 1'b0;
    chk("done_still", 128'(done), 128'd1);

    // Random keys, random gaps, disturbances on next/load_en during expansion
    for (int run = 0; run < 2; run++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load_key(k, 16);
      for (int r = 1; r <= NR; r++) begin
        idle($urandom_range(0, 3));
        pulse_next(16);
        if (r == 2 || r == 5 + run) begin
          idle(4);
          next = 1'b1; load_en = 1'b1;
          repeat (4) begin key_in = 8'($urandom); tick(); end
          next = 1'b0; load_en = 1'b0; key_in = 8'h00;
          idle(12);
        end else begin
          idle(16);
        end
      end
      idle(2);
      chk("done_random_run", 128'(done), 128'd1);
    end

    // Aborted load: nothing held, next must be ignored
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k, 10);
    tick();
    chk("abort_ready", 128'(ready), 128'd0);
    chk("abort_valid", 128'(key_valid), 128'd0);
    pulse_next(16);
    idle(20);
    chk("abort_ready_late", 128'(ready), 128'd0);
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k, 16);
    for (int r = 1; r <= 3; r++) begin
      idle($urandom_range(0, 4));
      pulse_next(16);
      idle(16);
    end

    // Asynchronous reset in the middle of round 4, byte 7
    load_key(FIPS_KEY, 16);
    for (int r = 1; r <= 3; r++) begin pulse_next(16); idle(16); end
    pulse_next(7);
    idle(8);
    rst = 1'b0;
    #1;
    chk("async_key_out", 128'(key_out), 128'd0);
    chk("async_key_valid", 128'(key_valid), 128'd0);
    chk("async_round_idx", 128'(round_idx), 128'd0);
    chk("async_ready", 128'(ready), 128'd0);
    chk("async_done", 128'(done), 128'd0);
    m_ready = 0; m_round = 0;
    idle(2);
    rst = 1'b1;
    idle(2);
    load_key(FIPS_KEY, 16);
    pulse_next(16);
    idle(18);
    chk("post_reset_round1", m_key, 128'ha0fafe1788542cb123a339392a6c7605);

    idle(3);
    chk("queue_drained", 128'(expq.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
